vga_stream_sequencer: RTL and testbench
=======================================

Name: vga_stream_sequencer

Overview:
Frame-level controller for the camera-to-VGA pixel filter stage. Generates the pixel read address and start/end-of-packet markers for a 320x240 stream, advancing one pixel per VGA handshake. Owns the filter configuration (filter_mode, mic_en, pitch), collects user and microphone updates, and commits them only at frame boundaries so no frame mixes two filters.

Parameters:
WIDTH, 320, active pixels per line
HEIGHT, 240, lines per frame
ADDR_W, 17, read address width (must satisfy 2^ADDR_W >= WIDTH*HEIGHT)
NUM_MODES, 3, filter_mode cycles 0..NUM_MODES-1
PITCH_HYST, 200, hysteresis margin for pitch band changes, in pitch units

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
mode_btn  in  1  raw, asynchronous mode-advance button, active-high
mic_en_in  in  1  raw, asynchronous microphone-enable switch
pitch_in  in  16  unsigned pitch estimate
pitch_valid  in  1  pitch_in is valid this cycle
vga_ready  in  1  downstream ready; a pixel is consumed on each cycle where vga_ready=1 in STREAM
rd_addr  out  ADDR_W  pixel-buffer address of the current pixel
rd_en  out  1  read strobe, equal to the consume condition
start_p  out  1  high while the current pixel is index 0
end_p  out  1  high while the current pixel is index WIDTH*HEIGHT-1
filter_mode  out  3  committed filter selection
mic_en  out  1  committed microphone enable
pitch  out  16  committed pitch value
pitch_band  out  2  committed band: 0 <=3000, 1 <=5000, 2 <=8000, 3 >8000
frame_done  out  1  one-cycle pulse when the last pixel is consumed

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, pixel index=0, rd_addr=0, rd_en=0, start_p=0, end_p=0, filter_mode=0, mic_en=0, pitch=0, pitch_band=0, frame_done=0, pending_mode=0, cand_pitch=0, cand_band=0, both sync chains=0.
- FSM:
  - IDLE: exactly one cycle after reset release, then STREAM.
  - STREAM: streams pixels.
  - Any reset assertion returns the FSM to IDLE immediately. The partial frame is abandoned and the next frame starts at index 0.
- Consume = (state==STREAM) & vga_ready. The pixel index increments on consume and wraps from WIDTH*HEIGHT-1 to 0. It holds for any number of cycles with vga_ready=0.
- rd_addr = pixel index, zero-extended to ADDR_W. start_p and end_p are combinational decodes of the pixel index, gated by STREAM. They are 0 in IDLE.
- Commit event = consume & end_p. On the commit cycle's clock edge:
  - filter_mode <= pending_mode
  - mic_en <= synced mic level
  - pitch <= cand_pitch
  - pitch_band <= cand_band
  - frame_done=1 for that one cycle.
- mode_btn: 2-FF synchroniser, then rising-edge detect. Each edge sets pending_mode <= (pending_mode+1) mod NUM_MODES. Multiple edges within a frame accumulate.
  - Edge on the commit cycle: the incremented value is the one committed.
- mic_en_in: 2-FF synchroniser. Only the level sampled on the commit cycle matters.
- Pitch band, computed on each pitch_valid=1 sample:
  - Raw band b from pitch_in using the thresholds 3000, 5000 and 8000, with boundaries inclusive on the upper side.
  - If b==cand_band: cand_pitch <= pitch_in.
  - If b!=cand_band: accept (cand_band<=b, cand_pitch<=pitch_in) only when pitch_in lies at least PITCH_HYST inside band b. That means pitch_in > lower(b)+PITCH_HYST and pitch_in <= upper(b)-PITCH_HYST, with band 0 having no lower bound and band 3 no upper bound. Otherwise ignore the sample.
  - Comparisons are done at 17 bits to avoid overflow.
- pitch_valid and a commit on the same cycle: the commit takes the pre-update candidate. The new sample lands in the candidate for the next frame.
- Latency:
  - rd_addr changes on the clock edge after the consume.
  - Configuration outputs change on the clock edge after the commit, so they are stable for all of the next frame.

Test Plan:
- Release reset, hold vga_ready=1 -> start_p on the 2nd cycle after release; end_p and frame_done exactly 76800 consumes later; rd_addr returns to 0; start_p reasserts on the next cycle.
- Toggle vga_ready with a random 50% pattern -> rd_addr advances only on ready cycles; exactly 76800 rd_en pulses per frame; start_p and end_p hold during stalls.
- mode_btn pulsed at pixel 1000 and again at 40000 -> filter_mode stays 0 for the frame, becomes 2 after the commit; a third press wraps it to 0 at the next commit.
- mode_btn edge landing on the commit cycle, and mic_en_in raised mid-frame -> the edge is included in the committed filter_mode; mic_en goes to 1 only at the frame end.
- Pitch samples 2900, 3100, 3300 with cand_band=0 -> 3100 is rejected and 3300 is accepted (band 1); 2850 is then rejected; after the commit, pitch=3300 and pitch_band=1.
- Assert reset at pixel 5000 with a mode press pending -> all outputs return to reset values immediately and pending_mode clears; after release the stream restarts at index 0 with filter_mode=0.

Source files
------------

// File: rtl/vga_stream_sequencer.sv
// vga_stream_sequencer: pixel address / SOP / EOP generator for the VGA
// filter stream, with frame-boundary commit of filter configuration.
//
// Ports:
//   clk, reset         clock, async active-low reset
//   mode_btn           raw button; each rising edge advances pending mode
//   mic_en_in          raw mic-enable switch, sampled at commit
//   pitch_in/valid     pitch estimate feeding the hysteretic band tracker
//   vga_ready          downstream ready; consume = STREAM & vga_ready
//   rd_addr, rd_en     pixel read address and read strobe
//   start_p, end_p     first / last pixel markers (0 outside STREAM)
//   filter_mode,mic_en committed configuration, updated after last pixel
//   pitch, pitch_band  committed pitch and band
//   frame_done         one-cycle pulse following the last-pixel consume
module vga_stream_sequencer #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int ADDR_W     = 17,
    parameter int NUM_MODES  = 3,
    parameter int PITCH_HYST = 200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode_btn,
    input  logic              mic_en_in,
    input  logic [15:0]       pitch_in,
    input  logic              pitch_valid,
    input  logic              vga_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic              start_p,
    output logic              end_p,
    output logic [2:0]        filter_mode,
    output logic              mic_en,
    output logic [15:0]       pitch,
    output logic [1:0]        pitch_band,
    output logic              frame_done
);

    localparam int              TOTAL    = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(TOTAL - 1);
    localparam logic [2:0]      MODE_MAX = 3'(NUM_MODES - 1);
    localparam logic [16:0]     HYST     = 17'(PITCH_HYST);
    localparam logic [16:0]     TH1      = 17'd3000;
    localparam logic [16:0]     TH2      = 17'd5000;
    localparam logic [16:0]     TH3      = 17'd8000;

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_stream;
    logic               w_consume;
    logic               w_commit;

    logic [ADDR_W-1:0]  r_idx;
    logic [1:0]         r_btn_sync;
    logic               r_btn_q;
    logic [1:0]         r_mic_sync;
    logic               w_btn_rise;
    logic [2:0]         r_pend;
    logic [2:0]         w_pend_next;

    logic [15:0]        r_cand_pitch;
    logic [1:0]         r_cand_band;
    logic [16:0]        w_p17;
    logic [1:0]         w_band;
    logic               w_lo_ok;
    logic               w_hi_ok;
    logic               w_accept;

    logic [2:0]         r_mode;
    logic               r_mic;
    logic [15:0]        r_pitch;
    logic [1:0]         r_band;
    logic               r_frame_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // IDLE lasts exactly one cycle after reset release.
    always_comb begin
        w_next   = r_state;
        w_stream = 1'b0;
        unique case (r_state)
            S_IDLE:   w_next = S_STREAM;
            S_STREAM: begin
                w_next   = S_STREAM;
                w_stream = 1'b1;
            end
        endcase
    end

    assign w_consume = w_stream & vga_ready;
    assign w_commit  = w_consume & (r_idx == LAST);

    assign rd_addr = r_idx;
    assign rd_en   = w_consume;
    assign start_p = w_stream & (r_idx == '0);
    assign end_p   = w_stream & (r_idx == LAST);

    // Edge on the commit cycle must be included in the committed mode,
    // so the commit takes the post-increment value.
    assign w_btn_rise = r_btn_sync[1] & ~r_btn_q;
    always_comb begin
        w_pend_next = r_pend;
        if (w_btn_rise)
            w_pend_next = (r_pend >= MODE_MAX) ? 3'd0 : r_pend + 3'd1;
    end

    // Band thresholds are inclusive on the upper side; a band change
    // needs the sample to sit HYST inside the new band.
    assign w_p17 = {1'b0, pitch_in};
    always_comb begin
        if (w_p17 <= TH1)      w_band = 2'd0;
        else if (w_p17 <= TH2) w_band = 2'd1;
        else if (w_p17 <= TH3) w_band = 2'd2;
        else                   w_band = 2'd3;
    end

    always_comb begin
        w_lo_ok = 1'b1;
        w_hi_ok = 1'b1;
        unique case (w_band)
            2'd0: w_hi_ok = w_p17 <= TH1 - HYST;
            2'd1: begin
                w_lo_ok = w_p17 > TH1 + HYST;
                w_hi_ok = w_p17 <= TH2 - HYST;
            end
            2'd2: begin
                w_lo_ok = w_p17 > TH2 + HYST;
                w_hi_ok = w_p17 <= TH3 - HYST;
            end
            2'd3: w_lo_ok = w_p17 > TH3 + HYST;
        endcase
    end

    assign w_accept = pitch_valid &
                      ((w_band == r_cand_band) | (w_lo_ok & w_hi_ok));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx        <= '0;
            r_btn_sync   <= '0;
            r_btn_q      <= 1'b0;
            r_mic_sync   <= '0;
            r_pend       <= '0;
            r_cand_pitch <= '0;
            r_cand_band  <= '0;
            r_mode       <= '0;
            r_mic        <= 1'b0;
            r_pitch      <= '0;
            r_band       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_btn_sync   <= {r_btn_sync[0], mode_btn};
            r_btn_q      <= r_btn_sync[1];
            r_mic_sync   <= {r_mic_sync[0], mic_en_in};
            r_pend       <= w_pend_next;
            r_frame_done <= w_commit;
            if (w_consume)
                r_idx <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
            if (w_accept) begin
                r_cand_pitch <= pitch_in;
                r_cand_band  <= w_band;
            end
            // Candidate registers feed the commit, so a same-cycle
            // sample lands in the following frame.
            if (w_commit) begin
                r_mode  <= w_pend_next;
                r_mic   <= r_mic_sync[1];
                r_pitch <= r_cand_pitch;
                r_band  <= r_cand_band;
            end
        end
    end

    assign filter_mode = r_mode;
    assign mic_en      = r_mic;
    assign pitch       = r_pitch;
    assign pitch_band  = r_band;
    assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_vga_stream_sequencer.sv
// tb_vga_stream_sequencer: directed bench with a small frame (20x10)
// so several frames fit; config commits checked via scoreboard queue.
module tb_vga_stream_sequencer;

    localparam int W     = 20;
    localparam int H     = 10;
    localparam int AW    = 17;
    localparam int LASTI = W * H - 1;

    typedef struct packed {
        logic [2:0]  m;
        logic        mic;
        logic [15:0] p;
        logic [1:0]  b;
    } cfg_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          mode_btn;
    logic          mic_en_in;
    logic [15:0]   pitch_in;
    logic          pitch_valid;
    logic          vga_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic          start_p;
    logic          end_p;
    logic [2:0]    filter_mode;
    logic          mic_en;
    logic [15:0]   pitch;
    logic [1:0]    pitch_band;
    logic          frame_done;

    int   n_cmp = 0;
    int   n_err = 0;
    cfg_t exp_q[$];

    vga_stream_sequencer #(
        .WIDTH(W), .HEIGHT(H), .ADDR_W(AW),
        .NUM_MODES(3), .PITCH_HYST(200)
    ) dut (
        .clk(clk), .reset(reset),
        .mode_btn(mode_btn), .mic_en_in(mic_en_in),
        .pitch_in(pitch_in), .pitch_valid(pitch_valid),
        .vga_ready(vga_ready),
        .rd_addr(rd_addr), .rd_en(rd_en),
        .start_p(start_p), .end_p(end_p),
        .filter_mode(filter_mode), .mic_en(mic_en),
        .pitch(pitch), .pitch_band(pitch_band),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Pixel-stream model: index, STREAM flag, expected frame_done.
    bit         m_stream;
    int         m_idx;
    bit         m_fd;
    bit         m_cons;
    logic [3:0] m_flags;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_addr", 32'(rd_addr), 32'd0);
            chk("rst_flags", 32'({rd_en, start_p, end_p, frame_done}),
                32'd0);
            m_stream = 1'b0;
            m_idx    = 0;
            m_fd     = 1'b0;
        end else begin
            m_cons  = m_stream && vga_ready;
            m_flags = {m_cons, m_stream && m_idx == 0,
                       m_stream && m_idx == LASTI, m_fd};
            chk("rd_addr", 32'(rd_addr), 32'(m_idx));
            chk("en/sop/eop/done",
                32'({rd_en, start_p, end_p, frame_done}), 32'(m_flags));
            m_fd = m_cons && m_idx == LASTI;
            if (m_cons) m_idx = (m_idx == LASTI) ? 0 : m_idx + 1;
            m_stream = 1'b1;
        end
    end

    // Config monitor: pops on frame_done, otherwise expects stability.
    cfg_t cur;
    cfg_t got;

    always @(negedge clk) begin
        got = {filter_mode, mic_en, pitch, pitch_band};
        if (!reset) begin
            cur = '0;
            chk("rst_cfg", 32'(got), 32'd0);
        end else if (frame_done) begin
            if (exp_q.size() == 0) begin
                chk("cfg_q_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                cur = exp_q.pop_front();
                chk("cfg_commit", 32'(got), 32'(cur));
            end
        end else begin
            chk("cfg_hold", 32'(got), 32'(cur));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pixel(input int n);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(rd_en && int'(rd_addr) == n) && c < 2000);
        if (c >= 2000) chk("wait_pixel_timeout", 32'(c), 32'd0);
    endtask

    task automatic wait_done();
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!frame_done && c < 2000);
        if (c >= 2000) chk("wait_done_timeout", 32'(c), 32'd0);
    endtask

    task automatic press();
        step();
        mode_btn = 1'b1;
        repeat (3) step();
        mode_btn = 1'b0;
        step();
    endtask

    task automatic psample(input logic [15:0] v);
        step();
        pitch_in    = v;
        pitch_valid = 1'b1;
        step();
        pitch_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset       = 1'b1;
        mode_btn    = 1'b0;
        mic_en_in   = 1'b0;
        pitch_in    = '0;
        pitch_valid = 1'b0;
        vga_ready   = 1'b1;
        #1 reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;

        // frame 0: continuous ready
        exp_q.push_back(cfg_t'{3'd0, 1'b0, 16'd0, 2'd0});
        wait_done();

        // frame 1: random ready pattern
        exp_q.push_back(cfg_t'{3'd0, 1'b0, 16'd0, 2'd0});
        step();
        vga_ready = 1'($urandom_range(0, 1));
        c = 0;
        forever begin
            @(negedge clk);
            if (frame_done || c > 2000) break;
            step();
            vga_ready = 1'($urandom_range(0, 1));
            c++;
        end
        if (c > 2000) chk("rand_frame_timeout", 32'(c), 32'd0);
        step();
        vga_ready = 1'b1;

        // frame 2: two presses -> mode 2
        exp_q.push_back(cfg_t'{3'd2, 1'b0, 16'd0, 2'd0});
        wait_pixel(10);
        press();
        wait_pixel(150);
        press();
        wait_done();

        // frame 3: third press wraps, mic raised mid-frame
        exp_q.push_back(cfg_t'{3'd0, 1'b1, 16'd0, 2'd0});
        wait_pixel(30);
        press();
        wait_pixel(100);
        step();
        mic_en_in = 1'b1;
        wait_done();

        // frame 4: synced edge lands on the commit cycle
        exp_q.push_back(cfg_t'{3'd1, 1'b1, 16'd0, 2'd0});
        wait_pixel(LASTI - 3);
        step();
        mode_btn = 1'b1;
        wait_done();
        step();
        mode_btn = 1'b0;

        // frame 5: hysteresis 2900 ok, 3100 rej, 3300 acc, 2850 rej
        exp_q.push_back(cfg_t'{3'd1, 1'b1, 16'd3300, 2'd1});
        wait_pixel(5);
        psample(16'd2900);
        psample(16'd3100);
        psample(16'd3300);
        psample(16'd2850);
        wait_done();

        // frame 6: 5000 stays band 1; sample on commit cycle deferred
        exp_q.push_back(cfg_t'{3'd1, 1'b1, 16'd5000, 2'd1});
        wait_pixel(20);
        psample(16'd5000);
        wait_pixel(LASTI - 1);
        step();
        pitch_in    = 16'hFFFF;
        pitch_valid = 1'b1;
        step();
        pitch_valid = 1'b0;
        wait_done();

        // frame 7: deferred 65535 lands; mic dropped
        exp_q.push_back(cfg_t'{3'd1, 1'b0, 16'hFFFF, 2'd3});
        wait_pixel(100);
        step();
        mic_en_in = 1'b0;
        wait_done();

        // frame 8: press pending, then reset mid-frame
        exp_q.push_back(cfg_t'{3'd2, 1'b0, 16'hFFFF, 2'd3});
        wait_pixel(20);
        press();
        wait_pixel(50);
        step();
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_immediate",
            32'({rd_addr, rd_en, start_p, end_p, filter_mode, mic_en,
                 pitch_band, frame_done}), 32'd0);
        chk("rst_pitch", 32'(pitch), 32'd0);
        repeat (3) step();
        reset = 1'b1;

        // frame 9: pending mode and candidate cleared by reset
        exp_q.push_back(cfg_t'{3'd0, 1'b0, 16'd0, 2'd0});
        wait_done();
        step();
        chk("q_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
